mem_arbiter_l3: RTL and testbench

- Shares one memory port between p_num_clients memory requesters (load/store units, fetch) in the L3 execute variant.
- Round-robin arbitration on requests, with a grant lock so a presented-but-stalled request stays stable.
- An in-order ID FIFO records which client owns each outstanding request; responses (in order from memory) are routed back by FIFO head.
- Sits between the execute units' memory client ports and the single memory interface.

---
 rtl/mem_arbiter_l3_pkg.sv | 44 ++++
 rtl/mem_arbiter_l3_arb_id_fifo.sv | 61 ++++++
 rtl/mem_arbiter_l3.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter_l3.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_l3_pkg.sv
// Shared memory-message definitions for the L3 execute memory arbiter.
`default_nettype none
package mem_arbiter_l3_pkg;

    typedef enum logic [1:0] {
        MEM_OP_READ  = 2'd0,
        MEM_OP_WRITE = 2'd1,
        MEM_OP_AMO   = 2'd2,
        MEM_OP_FENCE = 2'd3
    } t_op;

    localparam int OP_BITS       = 2;
    localparam int ADDR_BITS     = 32;
    localparam int STRB_BITS     = 4;
    localparam int DATA_BITS     = 32;
    localparam int DEF_OPAQ_BITS = 8;

    function automatic int mem_req_bits(input int opaq_bits);
        return OP_BITS + opaq_bits + ADDR_BITS + STRB_BITS + DATA_BITS;
    endfunction

    function automatic int mem_resp_bits(input int opaq_bits);
        return OP_BITS + opaq_bits + DATA_BITS;
    endfunction

    localparam int MEM_REQ_BITS  = mem_req_bits(DEF_OPAQ_BITS);
    localparam int MEM_RESP_BITS = mem_resp_bits(DEF_OPAQ_BITS);

    typedef struct packed {
        t_op                      op;
        logic [DEF_OPAQ_BITS-1:0] opaq;
        logic [ADDR_BITS-1:0]     addr;
        logic [STRB_BITS-1:0]     strb;
        logic [DATA_BITS-1:0]     data;
    } t_mem_req;

    typedef struct packed {
        t_op                      op;
        logic [DEF_OPAQ_BITS-1:0] opaq;
        logic [DATA_BITS-1:0]     data;
    } t_mem_resp;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_l3_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// mem_arbiter_l3_arb_id_fifo : in-order FIFO of client ids for outstanding
// memory requests.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module mem_arbiter_l3_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_l3.sv
// ----------------------------------------------------------------------------
// mem_arbiter_l3 : round-robin arbiter sharing one memory port between
// clients, with grant lock and in-order response routing.
// Optional: MEM_ARB_PERF_EN adds grant/conflict counters.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module mem_arbiter_l3
    import mem_arbiter_l3_pkg::*;
#(
    parameter int p_num_clients  = 2,
    parameter int p_opaq_bits    = 8,
    parameter int p_max_inflight = 4,
    localparam int REQ_BITS      = mem_req_bits(p_opaq_bits),
    localparam int RESP_BITS     = mem_resp_bits(p_opaq_bits)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [p_num_clients-1:0]          cl_req_val,
    output logic [p_num_clients-1:0]          cl_req_rdy,
    input  logic [p_num_clients*REQ_BITS-1:0] cl_req_msg,
    output logic [p_num_clients-1:0]          cl_resp_val,
    input  logic [p_num_clients-1:0]          cl_resp_rdy,
    output logic [RESP_BITS-1:0]              cl_resp_msg,
    output logic                              mem_req_val,
    input  logic                              mem_req_rdy,
    output logic [REQ_BITS-1:0]               mem_req_msg,
    input  logic                              mem_resp_val,
    output logic                              mem_resp_rdy,
    input  logic [RESP_BITS-1:0]              mem_resp_msg
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [p_num_clients*32-1:0]       perf_grants,
    output logic [31:0]                       perf_conflicts
`endif
);
    localparam int IDW = $clog2(p_num_clients);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [IDW-1:0] grant, head;
    logic           fifo_full, fifo_empty;
    logic           any_val, req_xfer, resp_xfer;
    logic           found;
    int             idx;

    assign any_val = |cl_req_val;

    always_comb begin
        grant = ptr_q;
        found = 1'b0;
        idx   = 0;
        if (lock_q) begin
            grant = lock_id_q;
        end else begin
            for (int k = 0; k < p_num_clients; k++) begin
                idx = (int'(ptr_q) + k) % p_num_clients;
                if (!found && cl_req_val[idx]) begin
                    grant = IDW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Outputs are gated by rst so every handshake is quiet during reset.
    assign mem_req_val = rst && (any_val || lock_q) && !fifo_full;
    assign mem_req_msg = cl_req_msg[int'(grant)*REQ_BITS +: REQ_BITS];
    assign req_xfer    = mem_req_val && mem_req_rdy;

    always_comb begin
        for (int i = 0; i < p_num_clients; i++) begin
            cl_req_rdy[i]  = rst && (grant == IDW'(i)) && mem_req_rdy && !fifo_full;
            cl_resp_val[i] = rst && mem_resp_val && !fifo_empty && (head == IDW'(i));
        end
    end

    assign mem_resp_rdy = rst && !fifo_empty && cl_resp_rdy[head];
    assign cl_resp_msg  = mem_resp_msg;
    assign resp_xfer    = mem_resp_val && mem_resp_rdy;

    always_comb begin
        ptr_d     = ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (req_xfer) begin
            ptr_d  = (grant == IDW'(p_num_clients - 1)) ? '0 : grant + 1'b1;
            lock_d = 1'b0;
        end else if (mem_req_val) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    mem_arbiter_l3_arb_id_fifo #(
        .DEPTH (p_max_inflight),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (req_xfer),
        .push_data_i (grant),
        .pop_i       (resp_xfer),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_grants_q [p_num_clients];
    logic [31:0] perf_conflicts_q;
    logic        conflict;

    assign conflict = ($countones(cl_req_val) >= 2) ||
                      (any_val && (fifo_full || !mem_req_rdy));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < p_num_clients; i++) perf_grants_q[i] <= '0;
            perf_conflicts_q <= '0;
        end else begin
            if (req_xfer && (perf_grants_q[grant] != '1))
                perf_grants_q[grant] <= perf_grants_q[grant] + 32'd1;
            if (conflict && (perf_conflicts_q != '1))
                perf_conflicts_q <= perf_conflicts_q + 32'd1;
        end
    end

    for (genvar g = 0; g < p_num_clients; g++) begin : g_perf_out
        assign perf_grants[g*32 +: 32] = perf_grants_q[g];
    end
    assign perf_conflicts = perf_conflicts_q;
`endif

`ifndef SYNTHESIS
    a_resp_on_empty: assert property (@(posedge clk) disable iff (!rst)
        !(mem_resp_val && fifo_empty))
        else $error("mem_arbiter_l3: memory response with no outstanding request");
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_l3.sv
// Directed, table-driven bench for mem_arbiter_l3 (2 clients, 4 in flight).
`default_nettype none
module tb_mem_arbiter_l3;
    import mem_arbiter_l3_pkg::*;

    localparam int N    = 2;
    localparam int OPQ  = 8;
    localparam int INF  = 4;
    localparam int RQB  = mem_req_bits(OPQ);
    localparam int RSB  = mem_resp_bits(OPQ);
    localparam int NV   = 21;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     cl_req_val = '0;
    logic [N-1:0]     cl_req_rdy;
    logic [N*RQB-1:0] cl_req_msg;
    logic [N-1:0]     cl_resp_val;
    logic [N-1:0]     cl_resp_rdy = '0;
    logic [RSB-1:0]   cl_resp_msg;
    logic             mem_req_val;
    logic             mem_req_rdy = 1'b0;
    logic [RQB-1:0]   mem_req_msg;
    logic             mem_resp_val = 1'b0;
    logic             mem_resp_rdy;
    logic [RSB-1:0]   mem_resp_msg = '0;
`ifdef MEM_ARB_PERF_EN
    logic [N*32-1:0]  perf_grants;
    logic [31:0]      perf_conflicts;
`endif

    mem_arbiter_l3 #(
        .p_num_clients  (N),
        .p_opaq_bits    (OPQ),
        .p_max_inflight (INF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cl_req_val   (cl_req_val),
        .cl_req_rdy   (cl_req_rdy),
        .cl_req_msg   (cl_req_msg),
        .cl_resp_val  (cl_resp_val),
        .cl_resp_rdy  (cl_resp_rdy),
        .cl_resp_msg  (cl_resp_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .mem_resp_msg (mem_resp_msg)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_grants    (perf_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rv;
        logic       mrr;
        logic       mrv;
        logic [1:0] crr;
        logic       e_mval;
        logic [1:0] e_rdy;
        int         e_gnt;
        logic [1:0] e_cresp;
        logic       e_mrdy;
    } vec_t;

    vec_t           vecs [NV];
    logic [RQB-1:0] msg [N];
    int             passed = 0;
    int             total  = 0;

    function automatic vec_t mk(input logic [1:0] rv, input logic mrr, input logic mrv,
                                input logic [1:0] crr, input logic e_mval,
                                input logic [1:0] e_rdy, input int e_gnt,
                                input logic [1:0] e_cresp, input logic e_mrdy);
        vec_t v;
        v.rv = rv; v.mrr = mrr; v.mrv = mrv; v.crr = crr;
        v.e_mval = e_mval; v.e_rdy = e_rdy; v.e_gnt = e_gnt;
        v.e_cresp = e_cresp; v.e_mrdy = e_mrdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    initial begin
        t_mem_req r;
        r.op = MEM_OP_READ;  r.opaq = 8'h10; r.addr = 32'h0000_1000;
        r.strb = 4'hF; r.data = 32'hA0A0_0000; msg[0] = r;
        r.op = MEM_OP_WRITE; r.opaq = 8'h21; r.addr = 32'h0000_2004;
        r.strb = 4'h3; r.data = 32'hB1B1_1111; msg[1] = r;
        cl_req_msg = {msg[1], msg[0]};

        //          rv     mrr   mrv   crr    mval  rdy    g  cresp  mrdy
        // Alternating grants filling the FIFO, then full blocking.
        vecs[0]  = mk(2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 2'b00, 1'b0);
        vecs[1]  = mk(2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1, 2'b00, 1'b1);
        vecs[2]  = mk(2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 2'b00, 1'b1);
        vecs[3]  = mk(2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1, 2'b00, 1'b1);
        vecs[4]  = mk(2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 0, 2'b01, 1'b1);
        vecs[5]  = mk(2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 2'b00, 1'b1);
        // Head is client 1, which is not ready for two cycles.
        vecs[6]  = mk(2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1, 2'b10, 1'b0);
        vecs[7]  = mk(2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1, 2'b10, 1'b0);
        vecs[8]  = mk(2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 1, 2'b10, 1'b1);
        vecs[9]  = mk(2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b10, 1, 2'b01, 1'b1);
        vecs[10] = mk(2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b10, 1, 2'b10, 1'b1);
        vecs[11] = mk(2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b10, 1, 2'b01, 1'b1);
        vecs[12] = mk(2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 2'b10, 1, 2'b00, 1'b0);
        // Stall with lock: client 1 joins but must not preempt client 0.
        vecs[13] = mk(2'b01, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 0, 2'b00, 1'b0);
        vecs[14] = mk(2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 0, 2'b00, 1'b0);
        vecs[15] = mk(2'b11, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 0, 2'b00, 1'b0);
        vecs[16] = mk(2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 2'b01, 0, 2'b00, 1'b0);
        vecs[17] = mk(2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1, 2'b00, 1'b1);
        // Simultaneous push and pop, then leave two outstanding.
        vecs[18] = mk(2'b01, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 0, 2'b01, 1'b1);
        vecs[19] = mk(2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 2'b10, 1, 2'b10, 1'b1);
        vecs[20] = mk(2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1, 2'b00, 1'b1);

        // Reset state with requests present.
        cl_req_val = 2'b11; mem_req_rdy = 1'b1; cl_resp_rdy = 2'b11;
        #3;
        chk("rst_mem_req_val", 128'(mem_req_val), 128'(1'b0));
        chk("rst_cl_req_rdy", 128'(cl_req_rdy), 128'(2'b00));
        chk("rst_mem_resp_rdy", 128'(mem_resp_rdy), 128'(1'b0));
        cl_req_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            cl_req_val   = vecs[i].rv;
            mem_req_rdy  = vecs[i].mrr;
            mem_resp_val = vecs[i].mrv;
            cl_resp_rdy  = vecs[i].crr;
            mem_resp_msg = RSB'(i * 37 + 5);
            #1;
            chk($sformatf("v%0d_mem_req_val", i), 128'(mem_req_val), 128'(vecs[i].e_mval));
            chk($sformatf("v%0d_cl_req_rdy", i), 128'(cl_req_rdy), 128'(vecs[i].e_rdy));
            chk($sformatf("v%0d_grant_msg", i), 128'(mem_req_msg), 128'(msg[vecs[i].e_gnt]));
            chk($sformatf("v%0d_cl_resp_val", i), 128'(cl_resp_val), 128'(vecs[i].e_cresp));
            chk($sformatf("v%0d_mem_resp_rdy", i), 128'(mem_resp_rdy), 128'(vecs[i].e_mrdy));
            chk($sformatf("v%0d_resp_msg", i), 128'(cl_resp_msg), 128'(RSB'(i * 37 + 5)));
        end

        // Asynchronous reset mid-stream with two outstanding (ids 0,1).
        @(negedge clk);
        cl_req_val = 2'b11; mem_req_rdy = 1'b1; mem_resp_val = 1'b0; cl_resp_rdy = 2'b11;
        #2 rst = 1'b0;
        #1;
        chk("arst_mem_req_val", 128'(mem_req_val), 128'(1'b0));
        chk("arst_cl_req_rdy", 128'(cl_req_rdy), 128'(2'b00));
        chk("arst_mem_resp_rdy", 128'(mem_resp_rdy), 128'(1'b0));
        mem_resp_val = 1'b1;
        #1;
        chk("arst_cl_resp_val", 128'(cl_resp_val), 128'(2'b00));
        @(negedge clk);
        mem_resp_val = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_ptr0_grant", 128'(mem_req_msg), 128'(msg[0]));
        chk("post_rst_fifo_empty", 128'(mem_resp_rdy), 128'(1'b0));
        cl_req_val = 2'b10;
        #1;
        chk("post_rst_c1_grant", 128'(mem_req_msg), 128'(msg[1]));
        chk("post_rst_c1_rdy", 128'(cl_req_rdy), 128'(2'b10));
        chk("post_rst_mem_req_val", 128'(mem_req_val), 128'(1'b1));
        @(negedge clk);
        cl_req_val = 2'b00; mem_resp_val = 1'b1; mem_resp_msg = RSB'(42'h1234);
        #1;
        chk("post_rst_resp_c1", 128'(cl_resp_val), 128'(2'b10));
        chk("post_rst_resp_rdy", 128'(mem_resp_rdy), 128'(1'b1));
        @(negedge clk);
        mem_resp_val = 1'b0;
        #1;
        chk("post_rst_drained", 128'(mem_resp_rdy), 128'(1'b0));
`ifdef MEM_ARB_PERF_EN
        chk("perf_grants_c0", 128'(perf_grants[31:0]), 128'(32'd0));
        chk("perf_grants_c1", 128'(perf_grants[63:32]), 128'(32'd1));
        chk("perf_conflicts", 128'(perf_conflicts), 128'(32'd0));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
